// File: rtl/alu_issue_stage.sv
// Operand-issue stage in front of the ALU: register file with writeback bypass,
// pending-write scoreboard for RAW stalls, and a registered valid/ready output.
module alu_issue_stage #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_alu_sel,
    input  logic [ADDR_W-1:0] in_rs1,
    input  logic [ADDR_W-1:0] in_rs2,
    input  logic              in_use_imm,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [XLEN-1:0]   wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        ALU_Sel,
    output logic [XLEN-1:0]   operand_0,
    output logic [XLEN-1:0]   operand_1,
    output logic [ADDR_W-1:0] out_rd
);

    logic [XLEN-1:0]   regs_q [NREG];
    logic [XLEN-1:0]   regs_d [NREG];
    logic [NREG-1:0]   pending_q, pending_d;

    logic              out_valid_q, out_valid_d;
    logic [3:0]        alu_sel_q, alu_sel_d;
    logic [XLEN-1:0]   operand_0_q, operand_0_d;
    logic [XLEN-1:0]   operand_1_q, operand_1_d;
    logic [ADDR_W-1:0] out_rd_q, out_rd_d;

    logic              wb_wr;
    logic              rs1_busy, rs2_busy;
    logic              hazard, accept;
    logic [XLEN-1:0]   rs1_val, rs2_val;

    assign wb_wr = wb_en && (wb_addr != '0);

    // A writeback landing this cycle both bypasses the read and releases the stall.
    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if (in_rs1 != '0)
            rs1_val = (wb_wr && wb_addr == in_rs1) ? wb_data : regs_q[in_rs1];
        if (in_rs2 != '0)
            rs2_val = (wb_wr && wb_addr == in_rs2) ? wb_data : regs_q[in_rs2];
        rs1_busy = pending_q[in_rs1] && !(wb_en && wb_addr == in_rs1);
        rs2_busy = pending_q[in_rs2] && !(wb_en && wb_addr == in_rs2);
        hazard   = in_valid && (rs1_busy || (!in_use_imm && rs2_busy));
        in_ready = (!out_valid_q || out_ready) && !hazard && !flush;
        accept   = in_valid && in_ready;
    end

    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            regs_d[i] = regs_q[i];
            if (i != 0 && wb_wr && wb_addr == ADDR_W'(i))
                regs_d[i] = wb_data;
        end
    end

    // Set-on-accept overrides clear-on-writeback; flush wipes everything.
    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_pend
            if (gi == 0) begin : g_zero
                assign pending_d[gi] = 1'b0;
            end else begin : g_bit
                assign pending_d[gi] = !flush &&
                    ((accept && in_rd == ADDR_W'(gi)) ||
                     (pending_q[gi] && !(wb_en && wb_addr == ADDR_W'(gi))));
            end
        end
    endgenerate

    always_comb begin
        out_valid_d = out_valid_q;
        alu_sel_d   = alu_sel_q;
        operand_0_d = operand_0_q;
        operand_1_d = operand_1_q;
        out_rd_d    = out_rd_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            alu_sel_d   = in_alu_sel;
            operand_0_d = rs1_val;
            operand_1_d = in_use_imm ? in_imm : rs2_val;
            out_rd_d    = in_rd;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
            pending_q   <= '0;
            out_valid_q <= 1'b0;
            alu_sel_q   <= '0;
            operand_0_q <= '0;
            operand_1_q <= '0;
            out_rd_q    <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
            pending_q   <= pending_d;
            out_valid_q <= out_valid_d;
            alu_sel_q   <= alu_sel_d;
            operand_0_q <= operand_0_d;
            operand_1_q <= operand_1_d;
            out_rd_q    <= out_rd_d;
        end
    end

    assign out_valid = out_valid_q;
    assign ALU_Sel   = alu_sel_q;
    assign operand_0 = operand_0_q;
    assign operand_1 = operand_1_q;
    assign out_rd    = out_rd_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed ops push expected outputs,
// a negedge monitor pops and compares on each output handshake.
module tb_alu_issue_stage;

    logic        clk, rst, flush;
    logic        in_valid, in_ready;
    logic [3:0]  in_alu_sel;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic        in_use_imm;
    logic [31:0] in_imm;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid, out_ready;
    logic [3:0]  ALU_Sel;
    logic [31:0] operand_0, operand_1;
    logic [4:0]  out_rd;

    alu_issue_stage #(.XLEN(32), .NREG(32), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_alu_sel(in_alu_sel), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_use_imm(in_use_imm), .in_imm(in_imm), .in_rd(in_rd),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .ALU_Sel(ALU_Sel), .operand_0(operand_0), .operand_1(operand_1),
        .out_rd(out_rd)
    );

    typedef struct packed {
        logic [3:0]  sel;
        logic [31:0] op0;
        logic [31:0] op1;
        logic [4:0]  rd;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive an op, check in_ready, and queue its expected output if it should be accepted.
    task automatic present(input string name, input logic [3:0] sel, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic use_imm, input logic [31:0] imm,
                           input logic [4:0] rd, input logic exp_ready, input logic push,
                           input logic [31:0] e0, input logic [31:0] e1);
        exp_t e;
        in_valid   = 1'b1;
        in_alu_sel = sel;
        in_rs1     = rs1;
        in_rs2     = rs2;
        in_use_imm = use_imm;
        in_imm     = imm;
        in_rd      = rd;
        #1;
        chk(name, in_ready, exp_ready);
        if (push && exp_ready) begin
            e = '{sel: sel, op0: e0, op1: e1, rd: rd};
            exp_q.push_back(e);
        end
        $display("issue %s sel=%0h rs1=%0d rs2=%0d imm=%0b rd=%0d ready=%0b",
                 name, sel, rs1, rs2, use_imm, rd, in_ready);
    endtask

    task automatic issue(input string name, input logic [3:0] sel, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic use_imm, input logic [31:0] imm,
                         input logic [4:0] rd, input logic push,
                         input logic [31:0] e0, input logic [31:0] e1);
        present(name, sel, rs1, rs2, use_imm, imm, rd, 1'b1, push, e0, e1);
        step();
        in_valid = 1'b0;
        wb_en    = 1'b0;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        wb_en = 1'b1; wb_addr = a; wb_data = d;
        step();
        wb_en = 1'b0;
    endtask

    // Monitor: compares on handshakes and checks output stability across stalls.
    logic        prev_stall = 1'b0, prev_rst = 1'b1, prev_flush = 1'b0;
    logic [31:0] prev_op0, prev_op1;
    logic [9:0]  prev_ctl;
    always @(negedge clk) begin
        exp_t e;
        if (prev_stall && !prev_rst && !prev_flush) begin
            chk("hold_op0", operand_0, prev_op0);
            chk("hold_op1", operand_1, prev_op1);
            chk("hold_ctl", {out_valid, ALU_Sel, out_rd}, prev_ctl);
        end
        if (out_valid && out_ready && !rst && !flush) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("out_sel", ALU_Sel, e.sel);
                chk("out_op0", operand_0, e.op0);
                chk("out_op1", operand_1, e.op1);
                chk("out_rd",  out_rd, e.rd);
                $display("out sel=%0h op0=%08h op1=%08h rd=%0d", ALU_Sel, operand_0, operand_1, out_rd);
            end
        end
        prev_stall = out_valid && !out_ready;
        prev_rst   = rst;
        prev_flush = flush;
        prev_op0   = operand_0;
        prev_op1   = operand_1;
        prev_ctl   = {out_valid, ALU_Sel, out_rd};
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_alu_sel = '0;
        in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_use_imm = 1'b0; in_imm = '0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b1;
        step();
        step();
        chk("rst_valid", out_valid, 0);
        chk("rst_sel", ALU_Sel, 0);
        chk("rst_op0", operand_0, 0);
        chk("rst_op1", operand_1, 0);
        chk("rst_rd", out_rd, 0);
        rst = 1'b0;

        // Reset register contents and x0 write suppression
        issue("read_x5", 4'h0, 5'd5, 5'd0, 1'b0, 32'h0, 5'd0, 1'b1, 32'h0, 32'h0);
        wb(5'd0, 32'hFFFF_FFFF);
        issue("read_x0", 4'h0, 5'd0, 5'd0, 1'b0, 32'h0, 5'd0, 1'b1, 32'h0, 32'h0);

        // Plain read, then same-cycle writeback bypass
        wb(5'd3, 32'h1234);
        issue("add_x3", 4'h0, 5'd3, 5'd3, 1'b0, 32'h0, 5'd0, 1'b1, 32'h1234, 32'h1234);
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h55;
        issue("bypass_x3", 4'h0, 5'd3, 5'd0, 1'b0, 32'h0, 5'd0, 1'b1, 32'h55, 32'h0);

        // RAW stall on x7 released by its writeback
        issue("set_x7", 4'h1, 5'd1, 5'd2, 1'b0, 32'h0, 5'd7, 1'b1, 32'h0, 32'h0);
        present("raw_stall", 4'h0, 5'd7, 5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        chk("raw_stall2", in_ready, 0);
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'd9;
        present("raw_release", 4'h0, 5'd7, 5'd0, 1'b0, 32'h0, 5'd0, 1'b1, 1'b1, 32'd9, 32'h0);
        step();
        in_valid = 1'b0; wb_en = 1'b0;

        // Output back-pressure, then back-to-back accept
        step();
        out_ready = 1'b0;
        issue("hold_a", 4'h2, 5'd3, 5'd0, 1'b1, 32'h10, 5'd0, 1'b1, 32'h55, 32'h10);
        present("hold_b", 4'h5, 5'd3, 5'd3, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        chk("hold_ready1", in_ready, 0);
        step();
        chk("hold_ready2", in_ready, 0);
        step();
        out_ready = 1'b1;
        present("b2b_b", 4'h5, 5'd3, 5'd3, 1'b0, 32'h0, 5'd0, 1'b1, 1'b1, 32'h55, 32'h55);
        step();
        in_valid = 1'b0;
        chk("b2b_valid", out_valid, 1);

        // Immediate op does not stall on a pending rs2
        issue("set_x6", 4'h0, 5'd0, 5'd0, 1'b0, 32'h0, 5'd6, 1'b1, 32'h0, 32'h0);
        issue("imm_nostall", 4'h3, 5'd3, 5'd6, 1'b1, 32'hFFFF_FFF0, 5'd0, 1'b1, 32'h55, 32'hFFFF_FFF0);

        // Flush discards the held op and clears pending[4]
        step();
        out_ready = 1'b0;
        issue("set_x4", 4'h0, 5'd0, 5'd0, 1'b0, 32'h0, 5'd4, 1'b0, 32'h0, 32'h0);
        flush = 1'b1; out_ready = 1'b1;
        present("flush_block", 4'h0, 5'd0, 5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_valid", out_valid, 0);
        issue("after_flush", 4'h4, 5'd4, 5'd3, 1'b0, 32'h0, 5'd0, 1'b1, 32'h0, 32'h55);

        // Reset in the middle of a stall
        step();
        out_ready = 1'b0;
        issue("set_x8", 4'h6, 5'd0, 5'd0, 1'b0, 32'h0, 5'd8, 1'b0, 32'h0, 32'h0);
        present("raw_x8", 4'h0, 5'd8, 5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        rst = 1'b1;
        step();
        chk("mrst_valid", out_valid, 0);
        chk("mrst_sel", ALU_Sel, 0);
        chk("mrst_op0", operand_0, 0);
        chk("mrst_op1", operand_1, 0);
        chk("mrst_rd", out_rd, 0);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        issue("post_rst", 4'hF, 5'd8, 5'd3, 1'b0, 32'h0, 5'd0, 1'b1, 32'h0, 32'h0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
        chk("drain", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
